// File: rtl/pc_score_accum.sv
// Streaming PCA score accumulator: sums y_i^2 / lambda_i into major and
// minor component scores and hands both to the threshold comparator.
module pc_score_accum #(
    parameter int PC_NUM     = 5,
    parameter int MAJ_PC_NUM = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_y,
    input  logic [15:0] in_inv_eig,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] maj_pc_score,
    output logic [31:0] min_pc_score
);

    localparam int IW = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PC_NUM - 1);
    localparam logic [IW-1:0] MAJ_LIM  = IW'(MAJ_PC_NUM);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic          s1_vld_q, s1_vld_d;
    logic [31:0]   s1_sq_q, s1_sq_d;
    logic [15:0]   s1_inv_q, s1_inv_d;
    logic [IW-1:0] s1_tag_q, s1_tag_d;

    logic          s2_vld_q, s2_vld_d;
    logic [31:0]   s2_term_q, s2_term_d;
    logic [IW-1:0] s2_tag_q, s2_tag_d;

    logic [31:0]   maj_acc_q, maj_acc_d;
    logic [31:0]   min_acc_q, min_acc_d;

    logic               accept;
    logic signed [31:0] y_ext;
    logic signed [31:0] sq_s;
    logic [31:0]        sq;
    logic [47:0]        prod;
    logic [32:0]        maj_sum;
    logic [32:0]        min_sum;
    logic [31:0]        maj_sat;
    logic [31:0]        min_sat;
    logic               s2_is_maj;
    logic               s2_is_last;
    logic               unused_prod_lsb;

    assign accept = in_valid & in_ready_q;

    // A Q8.8 square never exceeds 2^30, so 32 signed bits hold it exactly.
    assign y_ext = {{16{in_y[15]}}, in_y};
    assign sq_s  = y_ext * y_ext;
    assign sq    = sq_s;

    assign prod = {16'd0, s1_sq_q} * {32'd0, s1_inv_q};
    assign unused_prod_lsb = ^prod[15:0];

    assign maj_sum = {1'b0, maj_acc_q} + {1'b0, s2_term_q};
    assign min_sum = {1'b0, min_acc_q} + {1'b0, s2_term_q};
    assign maj_sat = maj_sum[32] ? 32'hFFFF_FFFF : maj_sum[31:0];
    assign min_sat = min_sum[32] ? 32'hFFFF_FFFF : min_sum[31:0];

    assign s2_is_maj  = (s2_tag_q < MAJ_LIM);
    assign s2_is_last = s2_vld_q && (s2_tag_q == LAST_IDX);

    always_comb begin
        s1_vld_d = accept;
        s1_sq_d  = s1_sq_q;
        s1_inv_d = s1_inv_q;
        s1_tag_d = s1_tag_q;
        idx_d    = idx_q;
        if (accept) begin
            s1_sq_d  = sq;
            s1_inv_d = in_inv_eig;
            s1_tag_d = idx_q;
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_term_d = s2_term_q;
        s2_tag_d  = s2_tag_q;
        if (s1_vld_q) begin
            s2_term_d = prod[47:16];
            s2_tag_d  = s1_tag_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        maj_acc_d   = maj_acc_q;
        min_acc_d   = min_acc_q;
        if (s2_vld_q) begin
            if (s2_is_maj) begin
                maj_acc_d = maj_sat;
            end else begin
                min_acc_d = min_sat;
            end
        end
        unique case (1'b1)
            (state_q == ST_ACCEPT): begin
                if (accept && (idx_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end
            end
            (state_q == ST_DRAIN): begin
                if (s2_is_last) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                end
            end
            (state_q == ST_HOLD): begin
                // Pipeline is empty here, so the clear never races an add.
                if (out_ready) begin
                    state_d     = ST_ACCEPT;
                    out_valid_d = 1'b0;
                    maj_acc_d   = '0;
                    min_acc_d   = '0;
                end
            end
            default: begin
                state_d     = ST_ACCEPT;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_ACCEPT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCEPT;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_sq_q     <= '0;
            s1_inv_q    <= '0;
            s1_tag_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_term_q   <= '0;
            s2_tag_q    <= '0;
            maj_acc_q   <= '0;
            min_acc_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s1_vld_q    <= s1_vld_d;
            s1_sq_q     <= s1_sq_d;
            s1_inv_q    <= s1_inv_d;
            s1_tag_q    <= s1_tag_d;
            s2_vld_q    <= s2_vld_d;
            s2_term_q   <= s2_term_d;
            s2_tag_q    <= s2_tag_d;
            maj_acc_q   <= maj_acc_d;
            min_acc_q   <= min_acc_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign maj_pc_score = maj_acc_q;
    assign min_pc_score = min_acc_q;

endmodule

// File: tb/tb_pc_score_accum.sv
// Scoreboard bench for pc_score_accum: default 5/2 instance plus a
// 6/1 instance used for the saturation case.
module tb_pc_score_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        in_valid;
    logic [15:0] in_y;
    logic [15:0] in_inv_eig;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_maj, a_min;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_maj, b_min;

    logic        in_ready, out_valid;
    logic [31:0] maj_sc, min_sc;

    always #5 clk = ~clk;

    pc_score_accum #(.PC_NUM(5), .MAJ_PC_NUM(2)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid & ~sel),
        .in_ready     (a_in_ready),
        .in_y         (in_y),
        .in_inv_eig   (in_inv_eig),
        .out_valid    (a_out_valid),
        .out_ready    (out_ready & ~sel),
        .maj_pc_score (a_maj),
        .min_pc_score (a_min)
    );

    pc_score_accum #(.PC_NUM(6), .MAJ_PC_NUM(1)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid & sel),
        .in_ready     (b_in_ready),
        .in_y         (in_y),
        .in_inv_eig   (in_inv_eig),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready & sel),
        .maj_pc_score (b_maj),
        .min_pc_score (b_min)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign maj_sc    = sel ? b_maj       : a_maj;
    assign min_sc    = sel ? b_min       : a_min;

    typedef struct {
        logic [31:0] maj;
        logic [31:0] min;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] vy[$];
    logic [15:0] vinv[$];
    int          pc_cur;
    int          maj_cur;
    int          n_chk;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic res_t model();
        res_t   r;
        longint am;
        longint an;
        am = 0;
        an = 0;
        for (int i = 0; i < pc_cur; i++) begin
            longint yi, sqv, prodv, term;
            yi    = longint'($signed(vy[i]));
            sqv   = yi * yi;
            prodv = sqv * longint'({48'd0, vinv[i]});
            term  = prodv >>> 16;
            if (i < maj_cur) am += term;
            else             an += term;
        end
        if (am > 64'h0_FFFF_FFFF) am = 64'h0_FFFF_FFFF;
        if (an > 64'h0_FFFF_FFFF) an = 64'h0_FFFF_FFFF;
        r.maj = am[31:0];
        r.min = an[31:0];
        return r;
    endfunction

    task automatic load(input logic [15:0] y0, input logic [15:0] y1,
                        input logic [15:0] y2, input logic [15:0] y3,
                        input logic [15:0] y4, input logic [15:0] inv);
        vy   = '{y0, y1, y2, y3, y4};
        vinv = '{inv, inv, inv, inv, inv};
    endtask

    task automatic send_beat(input logic [15:0] y, input logic [15:0] inv);
        int w;
        in_valid   = 1'b1;
        in_y       = y;
        in_inv_eig = inv;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_y       = 16'($urandom);
        in_inv_eig = 16'($urandom);
    endtask

    task automatic send_vec(input string name, input bit gapped,
                            output res_t got);
        int   n;
        res_t e;
        for (int i = 0; i < pc_cur; i++) begin
            if (gapped && i > 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (i == pc_cur - 1) exp_q.push_back(model());
            send_beat(vy[i], vinv[i]);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, 32'd2);
        check({name, "_in_ready_hold"}, {31'd0, in_ready}, 32'd0);
        e = exp_q.pop_front();
        check({name, "_maj"}, maj_sc, e.maj);
        check({name, "_min"}, min_sc, e.min);
        got = e;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_hs_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_hs_maj_clr"}, maj_sc, 32'd0);
        check({name, "_hs_min_clr"}, min_sc, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        res_t r;
        n_chk      = 0;
        n_fail     = 0;
        sel        = 1'b0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_y       = '0;
        in_inv_eig = '0;
        out_ready  = 1'b0;
        pc_cur     = 5;
        maj_cur    = 2;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_maj", maj_sc, 32'd0);
        check("rst_min", min_sc, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        load(16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0100, 16'h0100);
        send_vec("unit", 1'b0, r);
        check("unit_maj_const", r.maj, 32'h0000_0500);
        check("unit_min_const", r.min, 32'h0000_0100);
        handshake("unit");

        load(16'h0300, 16'hFE00, 16'h0100, 16'h0400, 16'h0080, 16'h0080);
        send_vec("scaled", 1'b0, r);
        check("scaled_maj_const", r.maj, 32'h0000_0680);
        check("scaled_min_const", r.min, 32'h0000_08A0);

        in_valid   = 1'b1;
        in_y       = 16'h7FFF;
        in_inv_eig = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_maj", maj_sc, r.maj);
            check("bp_min", min_sc, r.min);
        end
        in_valid = 1'b0;
        handshake("scaled");

        load(16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0100, 16'h0100);
        send_vec("after_bp", 1'b0, r);
        handshake("after_bp");

        send_beat(16'h0100, 16'h0100);
        send_beat(16'h0200, 16'h0100);
        send_beat(16'h0300, 16'h0100);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_maj", maj_sc, 32'd0);
        check("midrst_min", min_sc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_vec("post_midrst", 1'b0, r);
        check("post_midrst_maj_const", r.maj, 32'h0000_0500);
        handshake("post_midrst");

        load(16'h0300, 16'hFE00, 16'h0100, 16'h0400, 16'h0080, 16'h0080);
        send_vec("gapped", 1'b1, r);
        handshake("gapped");

        for (int k = 0; k < 3; k++) begin
            vy.delete();
            vinv.delete();
            for (int i = 0; i < 5; i++) begin
                vy.push_back(16'($urandom));
                vinv.push_back(16'($urandom));
            end
            send_vec("random", k[0], r);
            handshake("random");
        end

        sel     = 1'b1;
        pc_cur  = 6;
        maj_cur = 1;
        vy.delete();
        vinv.delete();
        for (int i = 0; i < 6; i++) begin
            vy.push_back(16'h8000);
            vinv.push_back(16'hFFFF);
        end
        @(posedge clk);
        #1;
        send_vec("sat", 1'b0, r);
        check("sat_maj_const", r.maj, 32'h3FFF_C000);
        check("sat_min_const", r.min, 32'hFFFF_FFFF);
        handshake("sat");

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
